// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame-format defaults and the
// baud-tick divisor used by the baud-rate generator.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;
   localparam int CLK_HZ         = 100_000_000;
   localparam int BAUD_RATE      = 9600;

   // Clock cycles between br_tick pulses; 100 MHz / (9600 * 16) rounds to 651
   localparam int BAUD_TICK_DIV  = CLK_HZ / (BAUD_RATE * OVERSAMPLE_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rxState_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. Both flops reset to
// RESET_VAL, so an idle-high line does not look like an edge after reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver. It oversamples the synchronised line with br_tick,
// validates the start bit at its centre, and samples the data and stop bits at their centres.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 br_tick_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_done_o,
   output logic                 frame_err_o,
   output logic                 rx_busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   rxState_e             state_q,    state_d;
   logic [TW-1:0]        tickCnt_q,  tickCnt_d;
   logic [BW-1:0]        bitCnt_q,   bitCnt_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic [DATA_BITS-1:0] rxData_q,   rxData_d;
   logic                 rxDone_q,   rxDone_d;
   logic                 frameErr_q, frameErr_d;
   logic                 rxSync;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rxSync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (rx_i),
      .q_o     (rxSync)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         tickCnt_q  <= '0;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         rxData_q   <= '0;
         rxDone_q   <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tickCnt_q  <= tickCnt_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         rxData_q   <= rxData_d;
         rxDone_q   <= rxDone_d;
         frameErr_q <= frameErr_d;
      end
   end

   // IDLE reacts to the line immediately; every other state advances only on br_tick.
   always_comb begin
      state_d    = state_q;
      tickCnt_d  = tickCnt_q;
      bitCnt_d   = bitCnt_q;
      shift_d    = shift_q;
      rxData_d   = rxData_q;
      rxDone_d   = 1'b0;
      frameErr_d = frameErr_q;

      case (state_q)
         IDLE: begin
            if (!rxSync) begin
               state_d   = START;
               tickCnt_d = '0;
            end
         end

         START: begin
            if (br_tick_i) begin
               if (tickCnt_q == TICK_MID) begin
                  tickCnt_d = '0;
                  if (!rxSync) begin
                     state_d  = DATA;
                     bitCnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end

         DATA: begin
            if (br_tick_i) begin
               if (tickCnt_q == TICK_LAST) begin
                  tickCnt_d = '0;
                  shift_d   = {rxSync, shift_q[DATA_BITS-1:1]};
                  if (bitCnt_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bitCnt_d = bitCnt_q + 1'b1;
                  end
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end

         STOP: begin
            if (br_tick_i) begin
               if (tickCnt_q == TICK_LAST) begin
                  // Leaving at mid stop bit lets a back-to-back start edge be caught.
                  state_d    = IDLE;
                  tickCnt_d  = '0;
                  rxData_d   = shift_q;
                  rxDone_d   = 1'b1;
                  frameErr_d = ~rxSync;
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rx_data_o   = rxData_q;
   assign rx_done_o   = rxDone_q;
   assign frame_err_o = frameErr_q;
   assign rx_busy_o   = (state_q != IDLE);

endmodule
